// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Definitions shared by the instruction memory blocks:
//   NOP_INST  - default filler word (addi x0,x0,0)
//   state_t   - top-level controller states (ST_BOOT, ST_RUN)
//   addr_ok() - alignment / range check for a byte address
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A byte address is usable when it is word aligned and every bit above
    // the word index (up to the bus width) is zero. The address arrives
    // zero-extended to 64 bits so one function serves every bus width.
    function automatic logic addr_ok(
        input logic [63:0] addr,
        input int          addr_width,
        input int          idx_bits
    );
        logic [63:0] hi_mask;
        hi_mask = ({64{1'b1}} << (idx_bits + 2)) & ~({64{1'b1}} << addr_width);
        return (addr[1:0] == 2'b00) && ((addr & hi_mask) == 64'd0);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// Single write port / single read port synchronous RAM. The read data is
// registered and only updated when re is high, so it holds its value while
// the consumer is stalled. Written in the plain form that maps to block RAM.
//
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write word index
//   wdata  in   write data
//   re     in   read enable (updates rdata on this edge)
//   raddr  in   read word index
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module imem_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch.sv
// -----------------------------------------------------------------------------
// imem_fetch
// Synchronous-read instruction memory between the IF-stage PC register and
// the IF/ID register. Valid/ready fetch port with one cycle of latency, a
// held response under stall, flush for redirects, a boot-load write port,
// error flagging and a saturating fetch counter.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_valid     fetch address presented
//   req_addr      fetch byte address (PC)
//   req_ready     fetch accepted when req_valid && req_ready
//   resp_valid    response valid
//   resp_inst     fetched word (NOP_INST when not valid or on error)
//   resp_err      fetch was misaligned or out of range
//   resp_ready    IF/ID consumes the response (0 = stall)
//   flush         drop held / in-flight response
//   prog_we       boot write strobe
//   prog_addr     boot write byte address
//   prog_data     boot write data
//   prog_done     boot load complete
//   prog_err      one-cycle pulse after a rejected boot write
//   boot_busy     high while in BOOT
//   fetch_count   accepted fetches, saturating
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | boot loader owns the RAM; fetch port blocked
// ST_RUN  | fetch port live; boot writes ignored; left only via reset
// -----------------------------------------------------------------------------
module imem_fetch
    import imem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    INST_WIDTH = 32,
    parameter int                    IMEM_DEPTH = 1024,
    parameter bit                    BOOT_LOAD  = 1'b1,
    parameter logic [INST_WIDTH-1:0] NOP_INST   = imem_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [INST_WIDTH-1:0] resp_inst,
    output logic                  resp_err,
    input  logic                  resp_ready,
    input  logic                  flush,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [INST_WIDTH-1:0] prog_data,
    input  logic                  prog_done,
    output logic                  prog_err,
    output logic                  boot_busy,
    output logic [31:0]           fetch_count
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    state_t                  state;
    logic                    resp_valid_q;
    logic                    resp_err_q;
    logic                    prog_err_q;
    logic [31:0]             fetch_count_q;

    logic                    req_ok;
    logic                    prog_ok;
    logic                    accept;
    logic                    consume;
    logic                    ram_we;
    logic [IDX_W-1:0]        req_idx;
    logic [IDX_W-1:0]        prog_idx;
    logic [INST_WIDTH-1:0]   ram_rdata;

    assign req_ok   = addr_ok(64'(req_addr), ADDR_WIDTH, IDX_W);
    assign prog_ok  = addr_ok(64'(prog_addr), ADDR_WIDTH, IDX_W);
    assign req_idx  = req_addr[IDX_W+1:2];
    assign prog_idx = prog_addr[IDX_W+1:2];

    assign req_ready = (state == ST_RUN) && !flush && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;
    assign consume   = resp_valid_q && resp_ready;
    assign ram_we    = (state == ST_BOOT) && prog_we && prog_ok;

    // Reads only on accept: the RAM output register is the response data
    // register and therefore holds through a stall without extra storage.
    imem_ram #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (INST_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (prog_idx),
        .wdata (prog_data),
        .re    (accept),
        .raddr (req_idx),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= BOOT_LOAD ? ST_BOOT : ST_RUN;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            prog_err_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            case (state)
                ST_BOOT: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    prog_err_q   <= prog_we && !prog_ok;
                    if (prog_done) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    prog_err_q <= 1'b0;
                    if (flush) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                    end else if (accept) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= !req_ok;
                        if (fetch_count_q != 32'hFFFF_FFFF) begin
                            fetch_count_q <= fetch_count_q + 32'd1;
                        end
                    end else if (consume) begin
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // RAM data is only meaningful for a valid, error-free response; every
    // other case presents the NOP word.
    assign resp_inst   = (resp_valid_q && !resp_err_q) ? ram_rdata : NOP_INST;
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign prog_err    = prog_err_q;
    assign boot_busy   = (state == ST_BOOT);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_imem_fetch.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch
// Self-checking bench for imem_fetch: directed boot/fetch/stall/flush/error
// sequences followed by random traffic, all compared every cycle against a
// transaction-level reference model. A second instance with BOOT_LOAD=0
// checks that fetch is open straight out of reset.
// -----------------------------------------------------------------------------
module tb_imem_fetch;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, resp_ready, flush;
    logic [31:0] req_addr;
    logic        prog_we, prog_done;
    logic [31:0] prog_addr, prog_data;

    logic        req_ready, resp_valid, resp_err, prog_err, boot_busy;
    logic [31:0] resp_inst, fetch_count;

    logic        d0_req_ready, d0_resp_valid, d0_resp_err, d0_prog_err, d0_boot_busy;
    logic [31:0] d0_resp_inst, d0_fetch_count;

    always #5 clk = ~clk;

    imem_fetch #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .IMEM_DEPTH (DEPTH),
        .BOOT_LOAD  (1'b1),
        .NOP_INST   (NOP)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .req_valid (req_valid), .req_addr (req_addr), .req_ready (req_ready),
        .resp_valid (resp_valid), .resp_inst (resp_inst), .resp_err (resp_err),
        .resp_ready (resp_ready), .flush (flush),
        .prog_we (prog_we), .prog_addr (prog_addr), .prog_data (prog_data),
        .prog_done (prog_done), .prog_err (prog_err), .boot_busy (boot_busy),
        .fetch_count (fetch_count)
    );

    imem_fetch #(
        .ADDR_WIDTH (32),
        .INST_WIDTH (32),
        .IMEM_DEPTH (64),
        .BOOT_LOAD  (1'b0),
        .NOP_INST   (NOP)
    ) dut_nb (
        .clk (clk), .rst_n (rst_n),
        .req_valid (1'b1), .req_addr (32'd0), .req_ready (d0_req_ready),
        .resp_valid (d0_resp_valid), .resp_inst (d0_resp_inst), .resp_err (d0_resp_err),
        .resp_ready (1'b1), .flush (1'b0),
        .prog_we (1'b0), .prog_addr (32'd0), .prog_data (32'd0),
        .prog_done (1'b0), .prog_err (d0_prog_err), .boot_busy (d0_boot_busy),
        .fetch_count (d0_fetch_count)
    );

    // reference model state
    bit          m_run;
    bit          m_valid;
    bit          m_err;
    bit          m_prog_err;
    logic [31:0] m_inst;
    logic [31:0] m_count;
    logic [31:0] m_mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
    endfunction

    // Called just after inputs are driven on a falling edge: checks all
    // outputs, advances the model by one clock, returns on the next falling edge.
    task automatic step();
        bit exp_ready;
        #1;
        exp_ready = m_run && !flush && (!m_valid || resp_ready);
        chk("req_ready",   32'(req_ready),  32'(exp_ready));
        chk("resp_valid",  32'(resp_valid), 32'(m_valid));
        chk("resp_inst",   resp_inst,       (m_valid && !m_err) ? m_inst : NOP);
        chk("resp_err",    32'(resp_err),   32'(m_valid && m_err));
        chk("boot_busy",   32'(boot_busy),  32'(!m_run));
        chk("prog_err",    32'(prog_err),   32'(m_prog_err));
        chk("fetch_count", fetch_count,     m_count);

        if (!m_run) begin
            m_prog_err = prog_we && bad_addr(prog_addr);
            if (prog_we && !bad_addr(prog_addr)) m_mem[prog_addr[11:2]] = prog_data;
            if (prog_done) m_run = 1'b1;
        end else begin
            m_prog_err = 1'b0;
            if (flush) begin
                m_valid = 1'b0;
                m_err   = 1'b0;
            end else if (req_valid && exp_ready) begin
                m_valid = 1'b1;
                m_err   = bad_addr(req_addr);
                m_inst  = m_err ? NOP : m_mem[req_addr[11:2]];
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            end else if (m_valid && resp_ready) begin
                m_valid = 1'b0;
                m_err   = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic rr, input logic fl);
        req_valid  = v;
        req_addr   = a;
        resp_ready = rr;
        flush      = fl;
        step();
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d, input logic done);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        prog_done = done;
        step();
        prog_we   = 1'b0;
        prog_done = 1'b0;
    endtask

    task automatic do_reset(input bit check_nb_running);
        if (check_nb_running) chk("nb_resp_valid_before_reset", 32'(d0_resp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_resp_valid",  32'(resp_valid), 32'd0);
        chk("rst_resp_inst",   resp_inst,       NOP);
        chk("rst_fetch_count", fetch_count,     32'd0);
        chk("rst_boot_busy",   32'(boot_busy),  32'd1);
        chk("rst_prog_err",    32'(prog_err),   32'd0);
        chk("rst_nb_count",    d0_fetch_count,  32'd0);
        m_run = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_prog_err = 1'b0;
        m_inst = NOP; m_count = 32'd0;
        req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b1; flush = 1'b0;
        prog_we = 1'b0; prog_addr = 32'd0; prog_data = 32'd0; prog_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("nb_req_ready_after_reset", 32'(d0_req_ready), 32'd1);
        chk("nb_boot_busy",             32'(d0_boot_busy), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r < 8)       return 32'($urandom_range(0, 15)) * 32'd4;
        else if (r == 8) return 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
        else             return ($urandom & 32'hFFFF_FFFC) | 32'h0000_1000;
    endfunction

    initial begin
        req_valid = 1'b0; req_addr = 32'd0; resp_ready = 1'b1; flush = 1'b0;
        prog_we = 1'b0; prog_addr = 32'd0; prog_data = 32'd0; prog_done = 1'b0;
        @(negedge clk);
        do_reset(1'b0);

        // boot load, including a rejected write and a write+done in one cycle
        prog(32'h0, 32'h0020_01B3, 1'b0);
        prog(32'h4, 32'h0070_0193, 1'b0);
        for (int i = 3; i < 16; i++) prog(32'(i * 4), $urandom, 1'b0);
        drive(1'b1, 32'h0, 1'b1, 1'b0);            // req_ready must stay 0 in BOOT
        prog(32'h1000, 32'hFFFF_FFFF, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);            // prog_err pulse visible here
        prog(32'h8, 32'hDEAD_BEEF, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);            // boot_busy has fallen

        // back-to-back fetch
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("count_after_b2b", fetch_count, 32'd2);

        // stall hold, then release with a same-cycle accept
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // flush with a competing request
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b1, 32'h4, 1'b1, 1'b1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // misaligned, out of range, then mem[0] still intact
        drive(1'b1, 32'h2, 1'b1, 1'b0);
        drive(1'b1, 32'h1000, 1'b1, 1'b0);
        drive(1'b1, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // same-cycle write+done result, then a RUN-time write that must be ignored
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        prog_we = 1'b1; prog_addr = 32'h8; prog_data = 32'h1234_5678;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        prog_we = 1'b0;
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            prog_we   = ($urandom_range(0, 7) == 0);
            prog_addr = rand_addr();
            prog_data = $urandom;
            prog_done = ($urandom_range(0, 7) == 0);
            drive(1'($urandom_range(0, 3) != 0), rand_addr(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
        end
        prog_we = 1'b0; prog_done = 1'b0;

        // asynchronous reset in the middle of a stall
        drive(1'b1, 32'h4, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        do_reset(1'b1);

        // memory survives reset
        prog(32'h0, 32'h0, 1'b1);
        m_mem[0] = 32'h0;
        drive(1'b1, 32'h4, 1'b1, 1'b0);
        drive(1'b1, 32'h8, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch.md
Name: imem_fetch

Overview:
Parametrised successor to the combinational instruction ROM used by the 5-stage RV32I pipeline. It is a synchronous-read instruction memory with the following features:
- byte addressing
- a valid/ready fetch port with 1-cycle latency and a held response under stall
- flush support for branch/jump redirects
- a boot-load write port that fills the memory before fetch is enabled
- error flagging and a fetch counter

It sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
ADDR_WIDTH, 32, width of byte address buses.
INST_WIDTH, 32, instruction word width (must be 32).
IMEM_DEPTH, 1024, number of instruction words (power of two).
BOOT_LOAD, 1, 1: reset enters BOOT and waits for prog_done; 0: reset enters RUN directly.
NOP_INST, 32'h0000_0013, word driven on resp_inst when there is no valid data or on error (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  IF stage presents fetch address.
req_addr  in  ADDR_WIDTH  byte address (PC).
req_ready  out  1  fetch accepted this cycle when req_valid&&req_ready.
resp_valid  out  1  resp_inst/resp_err valid.
resp_inst  out  INST_WIDTH  fetched instruction.
resp_err  out  1  fetch was misaligned or out of range.
resp_ready  in  1  IF/ID consumes response (0 = pipeline stall).
flush  in  1  drop any held or in-flight response (redirect).
prog_we  in  1  boot write strobe.
prog_addr  in  ADDR_WIDTH  boot byte address.
prog_data  in  INST_WIDTH  boot write data.
prog_done  in  1  boot load complete.
prog_err  out  1  1-cycle pulse: rejected boot write.
boot_busy  out  1  high while in BOOT state.
fetch_count  out  32  number of accepted fetches, saturating at 32'hFFFF_FFFF.

Behaviour:
- Reset (async, rst_n=0): state=BOOT if BOOT_LOAD else RUN; resp_valid=0, resp_inst=NOP_INST, resp_err=0, prog_err=0, fetch_count=0. Memory contents are not cleared. Reset mid-operation discards any response and any partially performed boot sequence; writes already performed remain.
- Word index = req_addr[log2(IMEM_DEPTH)+1:2].
- Fetch is bad if req_addr[1:0]!=0 or req_addr[ADDR_WIDTH-1:log2(IMEM_DEPTH)+2]!=0.
- State BOOT:
  - boot_busy=1, req_ready=0.
  - prog_we with a good prog_addr writes mem[index]=prog_data on that edge.
  - prog_we with a bad prog_addr performs no write; prog_err=1 for the next cycle.
  - prog_done=1 moves the state to RUN next cycle. If prog_we and prog_done are high in the same cycle, the write is performed, then RUN.
- State RUN:
  - boot_busy=0; prog_we is ignored and prog_err stays 0; prog_done is ignored.
  - Return to BOOT happens only via reset.
- req_ready = RUN && !flush && (!resp_valid || resp_ready).
- On an accepted fetch at edge t, at edge t+1: resp_valid=1, fetch_count increments (saturating).
  - Good address: resp_inst=mem[index], resp_err=0.
  - Bad address: resp_inst=NOP_INST, resp_err=1.
- A response is consumed when resp_valid && resp_ready. If consumed and no new accept, resp_valid=0 next edge and resp_inst returns to NOP_INST.
- Stall: while resp_valid && !resp_ready, resp_inst/resp_err/resp_valid hold unchanged and req_ready=0.
- Back-to-back: consume and accept in the same cycle gives one new response every cycle (full throughput).
- Flush has priority over everything in RUN. flush=1 at edge t gives resp_valid=0, resp_inst=NOP_INST, resp_err=0 after t. No fetch is accepted that cycle, and fetch_count is unchanged.
- Memory is read synchronously into the output register; the read port must be inferable as block RAM with a registered output.

Decomposition:
- Shared package imem_pkg: NOP_INST constant, state encoding (ST_BOOT, ST_RUN), function addr_ok(addr) returning the alignment/range check.
- One sub-module: imem_ram. It holds a 1 write / 1 read synchronous RAM with parameters DEPTH and WIDTH, and a read-enable input. Read enable = fetch accept, so the output holds under stall.
- The state machine, handshake, error logic and counter live in imem_fetch.

Test Plan:
1. Boot load:
   - Stimulus: reset, then prog_we at 0x0=0x002001B3 and 0x4=0x00700193, then prog_done.
   - Required: boot_busy falls the cycle after prog_done; req_ready=0 throughout BOOT.
   - Then fetch 0x0 and 0x4 back-to-back with resp_ready=1.
   - Required: resp_inst=0x002001B3 then 0x00700193 on consecutive cycles; fetch_count=2.
2. Stall hold:
   - Stimulus: fetch 0x4, then hold resp_ready=0 for 3 cycles.
   - Required: resp_valid=1 and resp_inst=0x00700193 stable all 3 cycles; req_ready=0.
   - Release resp_ready. Required: consumed, and the next request is accepted the same cycle.
3. Flush:
   - Stimulus: fetch 0x0 accepted, then flush=1 together with req_valid at 0x4.
   - Required: resp_valid=0, resp_inst=0x00000013 next cycle; 0x4 not accepted; fetch_count unchanged.
4. Errors:
   - Stimulus: fetch 0x2, then fetch 0x1000 with IMEM_DEPTH=1024.
   - Required: resp_err=1 and resp_inst=0x00000013 for both; fetch_count increments by 2.
   - Stimulus: boot write to 0x1000. Required: prog_err pulses 1 cycle; mem[0] is unchanged.
5. Same-cycle and ignored boot signals:
   - Stimulus: prog_we at 0x8=0xDEADBEEF with prog_done=1 in the same cycle; then fetch 0x8.
   - Required: resp_inst=0xDEADBEEF.
   - Stimulus: prog_we in RUN to 0x8. Required: ignored; a re-fetch still returns 0xDEADBEEF.
6. Reset mid-stall and BOOT_LOAD=0:
   - Stimulus: assert rst_n=0 while resp_valid=1.
   - Required: resp_valid=0, fetch_count=0 immediately (asynchronous).
   - With BOOT_LOAD=0, required: req_ready=1 on the first cycle after reset release.
